// File: rtl/reg_file_16x16.sv
// rtl/reg_file_16x16.sv - 16-entry register file with one-hot write select, bypassed registered reads and busy scoreboard
module reg_file_16x16 #(
  parameter int          DATA_W  = 16,
  parameter int unsigned R0_ZERO = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [15:0]       wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        rd_addr_a,
  input  logic [3:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              iss_valid,
  input  logic [15:0]       iss_sel,
  output logic [15:0]       busy,
  output logic              stall_a,
  output logic              stall_b,
  output logic              err_sel,
  input  logic              err_clr
);

  // With R0_ZERO, bit 0 is masked out of every write and issue so reg 0 stays 0 and never goes busy.
  localparam logic [15:0] SEL_MASK = (R0_ZERO != 0) ? 16'hFFFE : 16'hFFFF;

  function automatic logic f_onehot(input logic [15:0] v);
    return (v != 16'h0000) && ((v & (v - 16'd1)) == 16'h0000);
  endfunction

  logic [DATA_W-1:0] r_regs [16];
  logic [DATA_W-1:0] r_rd_a;
  logic [DATA_W-1:0] r_rd_b;
  logic [15:0]       r_busy;
  logic              r_err;

  logic              w_wr_onehot;
  logic              w_iss_onehot;
  logic [15:0]       w_wr_eff;
  logic [15:0]       w_iss_eff;
  logic              w_err_new;
  logic [DATA_W-1:0] w_rd_next_a;
  logic [DATA_W-1:0] w_rd_next_b;

  assign w_wr_onehot  = f_onehot(wr_sel);
  assign w_iss_onehot = f_onehot(iss_sel);
  assign w_wr_eff     = (wr_en && w_wr_onehot) ? (wr_sel & SEL_MASK) : 16'h0000;
  assign w_iss_eff    = (iss_valid && w_iss_onehot) ? (iss_sel & SEL_MASK) : 16'h0000;
  assign w_err_new    = (wr_en && !w_wr_onehot) || (iss_valid && !w_iss_onehot);

  assign w_rd_next_a  = w_wr_eff[rd_addr_a] ? wr_data : r_regs[rd_addr_a];
  assign w_rd_next_b  = w_wr_eff[rd_addr_b] ? wr_data : r_regs[rd_addr_b];

  // A same-cycle write-back releases the stall since the bypass delivers the data.
  assign stall_a = r_busy[rd_addr_a] & ~w_wr_eff[rd_addr_a];
  assign stall_b = r_busy[rd_addr_b] & ~w_wr_eff[rd_addr_b];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (w_wr_eff[i]) begin
          r_regs[i] <= wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_a <= '0;
      r_rd_b <= '0;
      r_busy <= 16'h0000;
      r_err  <= 1'b0;
    end else begin
      r_rd_a <= w_rd_next_a;
      r_rd_b <= w_rd_next_b;
      // Set has priority so a new producer keeps the register busy.
      r_busy <= w_iss_eff | (r_busy & ~w_wr_eff);
      if (w_err_new) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign rd_data_a = r_rd_a;
  assign rd_data_b = r_rd_b;
  assign busy      = r_busy;
  assign err_sel   = r_err;

endmodule

// File: tb/tb_reg_file_16x16.sv
// tb/tb_reg_file_16x16.sv - bench for reg_file_16x16, both R0_ZERO settings driven in parallel against a reference model
module tb_reg_file_16x16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wr_en;
  logic [15:0] wr_sel;
  logic [15:0] wr_data;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic        iss_valid;
  logic [15:0] iss_sel;
  logic        err_clr;

  logic [1:0][15:0] o_rda;
  logic [1:0][15:0] o_rdb;
  logic [1:0][15:0] o_busy;
  logic [1:0]       o_sta;
  logic [1:0]       o_stb;
  logic [1:0]       o_err;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_reg  [2][16];
  logic [15:0] m_rda  [2];
  logic [15:0] m_rdb  [2];
  logic [15:0] m_busy [2];
  logic        m_err  [2];

  always #5 clk = ~clk;

  reg_file_16x16 #(.DATA_W(16), .R0_ZERO(0)) dut0 (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(o_rda[0]), .rd_data_b(o_rdb[0]),
    .iss_valid(iss_valid), .iss_sel(iss_sel), .busy(o_busy[0]), .stall_a(o_sta[0]),
    .stall_b(o_stb[0]), .err_sel(o_err[0]), .err_clr(err_clr)
  );

  reg_file_16x16 #(.DATA_W(16), .R0_ZERO(1)) dut1 (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(o_rda[1]), .rd_data_b(o_rdb[1]),
    .iss_valid(iss_valid), .iss_sel(iss_sel), .busy(o_busy[1]), .stall_a(o_sta[1]),
    .stall_b(o_stb[1]), .err_sel(o_err[1]), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sel_index(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit is_onehot(input logic [15:0] v);
    return $countones(v) == 1;
  endfunction

  // Index of the register a write lands in this cycle, or -1 if none.
  function automatic int write_target(input int k);
    int w;
    if (!(wr_en && is_onehot(wr_sel))) return -1;
    w = sel_index(wr_sel);
    if (k == 1 && w == 0) return -1;
    return w;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) m_reg[k][i] = 16'h0;
      m_rda[k] = 16'h0; m_rdb[k] = 16'h0; m_busy[k] = 16'h0; m_err[k] = 1'b0;
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      int w;
      int s;
      w = write_target(k);
      m_rda[k] = (w == int'(rd_addr_a)) ? wr_data : m_reg[k][rd_addr_a];
      m_rdb[k] = (w == int'(rd_addr_b)) ? wr_data : m_reg[k][rd_addr_b];
      if (w >= 0) begin
        m_reg[k][w]  = wr_data;
        m_busy[k][w] = 1'b0;
      end
      if (iss_valid && is_onehot(iss_sel)) begin
        s = sel_index(iss_sel);
        if (!(k == 1 && s == 0)) m_busy[k][s] = 1'b1;
      end
      if ((wr_en && !is_onehot(wr_sel)) || (iss_valid && !is_onehot(iss_sel))) m_err[k] = 1'b1;
      else if (err_clr) m_err[k] = 1'b0;
    end
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.rda%0d", tag, k), o_rda[k], m_rda[k]);
      chk($sformatf("%s.rdb%0d", tag, k), o_rdb[k], m_rdb[k]);
      chk($sformatf("%s.busy%0d", tag, k), o_busy[k], m_busy[k]);
      chk($sformatf("%s.err%0d", tag, k), o_err[k], m_err[k]);
    end
  endtask

  // Stalls are checked mid-cycle, then the edge is taken and registered outputs checked.
  task automatic cycle(input string tag);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      int w;
      w = write_target(k);
      chk($sformatf("%s.sta%0d", tag, k), o_sta[k], m_busy[k][rd_addr_a] && (w != int'(rd_addr_a)));
      chk($sformatf("%s.stb%0d", tag, k), o_stb[k], m_busy[k][rd_addr_b] && (w != int'(rd_addr_b)));
    end
    @(posedge clk);
    model_clock();
    #1;
    check_regs(tag);
  endtask

  task automatic drive(input logic we, input logic [15:0] ws, input logic [15:0] wd,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic iv, input logic [15:0] is, input logic clr);
    wr_en = we; wr_sel = ws; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb;
    iss_valid = iv; iss_sel = is; err_clr = clr;
  endtask

  initial begin
    resetn = 1'b0;
    drive(0, 16'h0, 16'h0, 4'd0, 4'd0, 0, 16'h0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(0, 16'h0, 16'h0, 4'(i), 4'(15 - i), 0, 16'h0, 0);
      cycle("rd_init");
      chk("rd_init_const", o_rda[0], 16'h0000);
    end

    drive(1, 16'h0020, 16'hA5A5, 4'd5, 4'd0, 0, 16'h0, 0);
    cycle("bypass");
    chk("bypass_const", o_rda[0], 16'hA5A5);
    drive(0, 16'h0, 16'h0, 4'd5, 4'd5, 0, 16'h0, 0);
    cycle("stored");
    chk("stored_const", o_rdb[1], 16'hA5A5);

    drive(1, 16'h0030, 16'hFFFF, 4'd4, 4'd5, 0, 16'h0, 0);
    cycle("multisel");
    chk("multisel_err", o_err[0], 1'b1);
    drive(0, 16'h0, 16'h0, 4'd4, 4'd5, 0, 16'h0, 1);
    cycle("errclr");
    chk("errclr_const", o_err[0], 1'b0);
    drive(1, 16'h0000, 16'h1111, 4'd0, 4'd1, 0, 16'h0, 1);
    cycle("err_wins");
    drive(0, 16'h0, 16'h0, 4'd0, 4'd1, 1, 16'h0003, 0);
    cycle("iss_multi");
    drive(0, 16'h0, 16'h0, 4'd0, 4'd1, 0, 16'h0, 1);
    cycle("errclr2");

    drive(0, 16'h0, 16'h0, 4'd1, 4'd3, 1, 16'h0008, 0);
    cycle("issue3");
    chk("issue3_busy", o_busy[0], 16'h0008);
    drive(0, 16'h0, 16'h0, 4'd1, 4'd3, 0, 16'h0, 0);
    cycle("stall3");
    drive(1, 16'h0008, 16'hBEEF, 4'd3, 4'd3, 1, 16'h0008, 0);
    @(negedge clk);
    chk("wb_release_stall", o_stb[0], 1'b0);
    cycle("wb_iss3");
    chk("wb_iss3_busy", o_busy[0][3], 1'b1);
    drive(1, 16'h0008, 16'hCAFE, 4'd3, 4'd3, 0, 16'h0, 0);
    cycle("wb3");
    drive(1, 16'h0100, 16'h7777, 4'd8, 4'd3, 0, 16'h0, 0);
    cycle("wb_notbusy");

    drive(1, 16'h0001, 16'h1234, 4'd0, 4'd0, 1, 16'h0001, 0);
    cycle("r0_write");
    chk("r0_zero_rd", o_rda[1], 16'h0000);
    chk("r0_zero_busy", o_busy[1][0], 1'b0);
    drive(0, 16'h0, 16'h0, 4'd0, 4'd0, 0, 16'h0, 0);
    cycle("r0_read");

    for (int n = 0; n < 400; n++) begin
      logic [15:0] ws;
      logic [15:0] is;
      ws = ($urandom_range(0, 9) == 0) ? 16'($urandom) : (16'h1 << $urandom_range(0, 15));
      is = ($urandom_range(0, 9) == 0) ? 16'($urandom) : (16'h1 << $urandom_range(0, 15));
      drive(1'($urandom), ws, 16'($urandom), 4'($urandom), 4'($urandom),
            1'($urandom), is, $urandom_range(0, 3) == 0);
      cycle("rand");
    end

    for (int i = 0; i < 16; i++) begin
      drive(1, 16'h1 << i, 16'h1000 + 16'(i), 4'(i), 4'(i), 1, 16'h1 << i, 0);
      cycle("fill");
    end
    drive(0, 16'h0, 16'h0, 4'd7, 4'd9, 0, 16'h0, 0);
    cycle("full_busy");
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check_regs("async_rst");
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(0, 16'h0, 16'h0, 4'(i), 4'(15 - i), 0, 16'h0, 0);
      cycle("rd_after_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_16x16.md
Name: reg_file_16x16

Overview:
- 16-entry general-purpose register file.
- Consumes the one-hot 16-bit write-select vector produced by the 4-to-16 destination decoder.
- Provides two registered read ports with write-through bypass.
- Tracks in-flight destinations with a busy scoreboard so the issue stage can stall on read-after-write hazards.

Parameters:
- DATA_W, 16, register and data-path width in bits.
- R0_ZERO, 0, when 1: register 0 reads as zero and writes to it are discarded.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- resetn  input  1  asynchronous active-low reset
- wr_en  input  1  write-back strobe
- wr_sel  input  16  one-hot destination select from decoder
- wr_data  input  DATA_W  write-back data
- rd_addr_a  input  4  read port A address
- rd_addr_b  input  4  read port B address
- rd_data_a  output  DATA_W  read port A data, registered
- rd_data_b  output  DATA_W  read port B data, registered
- iss_valid  input  1  instruction issued; mark destination busy
- iss_sel  input  16  one-hot destination of issued instruction
- busy  output  16  scoreboard, bit i = register i has a pending write
- stall_a  output  1  source A register pending (combinational)
- stall_b  output  1  source B register pending (combinational)
- err_sel  output  1  sticky: a non-one-hot select was presented
- err_clr  input  1  synchronous clear of err_sel

Behaviour:
- Reset (resetn low, asynchronous): all 16 registers, rd_data_a, rd_data_b, busy and err_sel go to 0 immediately. Holds while low. First update on the first rising edge after release.
- Reset mid-operation discards pending writes and scoreboard state. No partial write occurs.
- Write validity: wv = wr_en & onehot(wr_sel), where onehot means exactly one bit is set.
  - wv: reg[i] <= wr_data for the single set bit i.
  - wr_en with wr_sel zero or multi-bit: no register changes; err_sel <= 1.
- R0_ZERO=1:
  - A write selecting bit 0 is dropped silently (not an error).
  - Reads of address 0 return 0, including through bypass.
  - busy[0] is never set.
- Read latency is 1 cycle. On each edge, rd_data_x <= value of reg[rd_addr_x].
- Bypass: if wv and wr_sel[rd_addr_x] in the same cycle, rd_data_x <= wr_data (the new value, not the stale one).
- Both ports may read the same address. Either or both may hit the bypass.
- Scoreboard:
  - Issue validity: iv = iss_valid & onehot(iss_sel). iss_valid with non-one-hot iss_sel: scoreboard unchanged; err_sel <= 1.
  - Per bit i: busy[i] <= (iv & iss_sel[i]) | (busy[i] & ~(wv & wr_sel[i])).
  - Simultaneous issue and write-back to the same register: set wins; busy stays 1 for the new producer.
  - Write-back to a non-busy register is legal; register is updated, busy stays 0.
- Stalls:
  - stall_x = busy[rd_addr_x] & ~(wv & wr_sel[rd_addr_x]). A write-back in the current cycle releases the stall because the bypass supplies the data.
  - Stalls ignore same-cycle issue (newly issued busy bits appear next cycle).
- err_sel:
  - Sticky until err_clr.
  - err_clr and a new error in the same cycle: err_sel stays 1 (error wins).
- No X propagation: register contents are defined from reset. Unused address combinations do not exist (4-bit address covers all 16 entries).

Test Plan:
- Reset then read all 16 addresses on both ports -> every rd_data = 0x0000, busy = 0x0000, err_sel = 0.
- Write 0xA5A5 with wr_sel=16'h0020, rd_addr_a=5 same cycle -> rd_data_a = 0xA5A5 next cycle (bypass); following cycle still 0xA5A5 from storage.
- Write with wr_sel=16'h0030 -> no register changes, err_sel = 1; then err_clr -> err_sel = 0 next cycle.
- iss_valid with iss_sel=16'h0008 -> busy=0x0008 and stall_b=1 for rd_addr_b=3. Write-back to reg 3 plus a new issue to reg 3 in the same cycle -> stall_b=0 that cycle, busy[3] remains 1.
- R0_ZERO=1: write 0x1234 to reg 0 -> rd_data_a for address 0 = 0x0000, err_sel = 0, busy[0] = 0.
- Assert resetn low asynchronously between edges while busy=0xFFFF and registers hold data -> busy, rd_data and registers read 0 immediately, before the next clock edge.
